// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM generator and its duty ramp stage.
package pwm_pkg;

    localparam int unsigned DUTY_W = 8;
    localparam logic [DUTY_W-1:0] PHASE_MAX = 8'hFF;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target-duty request handshake between a requester and the duty ramp stage.
interface pwm_duty_ramp_if;
    import pwm_pkg::*;

    duty_t tgt_duty;
    logic  tgt_valid;
    logic  tgt_ready;

    modport master (output tgt_duty, output tgt_valid, input tgt_ready);
    modport slave  (input tgt_duty, input tgt_valid, output tgt_ready);

endinterface

// File: rtl/pwm_phase_counter.sv
// Free-running 8-bit PWM phase counter with a strobe in the last cycle of each period.
module pwm_phase_counter
    import pwm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    output duty_t phase_q,
    output logic  boundary_c
);

    duty_t phase_d;

    always_comb begin
        phase_d = phase_q + DUTY_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    assign boundary_c = (phase_q == PHASE_MAX);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-limits the PWM duty toward a requested target, updating only at period boundaries.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned STEP             = 1,
    parameter int unsigned PERIODS_PER_STEP = 4,
    parameter int unsigned DIV_W            = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    pwm_duty_ramp_if.slave tgt_if,
    output duty_t          duty_out,
    output logic           period_start,
    output logic           ramp_busy,
    output logic           at_target
);

    localparam int unsigned SUM_W = DUTY_W + 1;
    localparam logic [SUM_W-1:0] STEP_W   = SUM_W'(STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIODS_PER_STEP - 1);

    ramp_state_e      state_q, state_d;
    duty_t            duty_q, duty_d;
    duty_t            target_q, target_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             period_start_q, period_start_d;
    logic             ramp_busy_q, ramp_busy_d;
    logic             at_target_q, at_target_d;

    duty_t            phase;
    logic             boundary;
    logic [SUM_W-1:0] up_sum;
    logic [SUM_W-1:0] dn_gap;
    duty_t            stepped;

    pwm_phase_counter u_phase (
        .clk        (clk),
        .reset      (reset),
        .phase_q    (phase),
        .boundary_c (boundary)
    );

    assign tgt_if.tgt_ready = enable;

    // One clamped step toward target; 9-bit math so neither direction can wrap.
    always_comb begin
        up_sum = SUM_W'(duty_q) + STEP_W;
        dn_gap = SUM_W'(duty_q) - SUM_W'(target_q);
        if (target_q > duty_q) begin
            stepped = (up_sum >= SUM_W'(target_q)) ? target_q : up_sum[DUTY_W-1:0];
        end else begin
            stepped = (dn_gap <= STEP_W) ? target_q : DUTY_W'(SUM_W'(duty_q) - STEP_W);
        end
    end

    // Priority: disable at boundary, then accept, then a divider-gated step.
    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        div_cnt_d   = div_cnt_q;
        at_target_d = 1'b0;

        if (!enable) begin
            if (boundary) begin
                duty_d    = '0;
                target_d  = '0;
                div_cnt_d = '0;
                state_d   = IDLE;
            end
        end else if (tgt_if.tgt_valid) begin
            target_d  = tgt_if.tgt_duty;
            div_cnt_d = '0;
            state_d   = (tgt_if.tgt_duty != duty_q) ? RAMP : IDLE;
        end else if ((state_q == RAMP) && boundary) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                duty_d    = stepped;
                if (stepped == target_q) begin
                    state_d     = IDLE;
                    at_target_d = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        period_start_d = (phase == PHASE_MAX);
        ramp_busy_d    = (state_d == RAMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            duty_q         <= '0;
            target_q       <= '0;
            div_cnt_q      <= '0;
            period_start_q <= 1'b0;
            ramp_busy_q    <= 1'b0;
            at_target_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            duty_q         <= duty_d;
            target_q       <= target_d;
            div_cnt_q      <= div_cnt_d;
            period_start_q <= period_start_d;
            ramp_busy_q    <= ramp_busy_d;
            at_target_q    <= at_target_d;
        end
    end

    assign duty_out     = duty_q;
    assign period_start = period_start_q;
    assign ramp_busy    = ramp_busy_q;
    assign at_target    = at_target_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: two instances (STEP=1/P=4 and STEP=8/P=1) share stimulus.
module tb_pwm_duty_ramp;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       tv;
    logic [7:0] td;

    logic [7:0] duty_o [2];
    logic       ps_o   [2];
    logic       busy_o [2];
    logic       at_o   [2];

    int nvec;
    int nbad;

    // Reference model state: duty is a closed-form function of the duty at the
    // last accept, the target, and the number of ramping boundaries since then.
    int m_cyc;
    int m_phase;
    int m_ps;
    int m_d0 [2];
    int m_tg [2];
    int m_nb [2];
    int m_du [2];
    int m_at [2];

    pwm_duty_ramp_if if_a ();
    pwm_duty_ramp_if if_b ();

    assign if_a.tgt_valid = tv;
    assign if_a.tgt_duty  = td;
    assign if_b.tgt_valid = tv;
    assign if_b.tgt_duty  = td;

    pwm_duty_ramp #(.STEP(1), .PERIODS_PER_STEP(4), .DIV_W(16)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .tgt_if(if_a),
        .duty_out(duty_o[0]), .period_start(ps_o[0]), .ramp_busy(busy_o[0]), .at_target(at_o[0])
    );

    pwm_duty_ramp #(.STEP(8), .PERIODS_PER_STEP(1), .DIV_W(16)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .tgt_if(if_b),
        .duty_out(duty_o[1]), .period_start(ps_o[1]), .ramp_busy(busy_o[1]), .at_target(at_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 8;
    endfunction

    function automatic int per_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int ramp_value(input int d0, input int tg, input int nb, input int i);
        int moved;
        moved = step_of(i) * (nb / per_of(i));
        if (tg >= d0) return (d0 + moved < tg) ? d0 + moved : tg;
        return (d0 - moved > tg) ? d0 - moved : tg;
    endfunction

    task automatic model_update();
        int bnd;
        int ramped;
        if (reset) begin
            m_cyc = 0; m_phase = 0; m_ps = 0;
            for (int i = 0; i < 2; i++) begin
                m_d0[i] = 0; m_tg[i] = 0; m_nb[i] = 0; m_du[i] = 0; m_at[i] = 0;
            end
        end else begin
            bnd = (m_phase == 255) ? 1 : 0;
            for (int i = 0; i < 2; i++) begin
                ramped = 0;
                if (!enable) begin
                    if (bnd != 0) begin m_d0[i] = 0; m_tg[i] = 0; m_nb[i] = 0; end
                end else if (tv) begin
                    m_d0[i] = m_du[i]; m_tg[i] = int'(td); m_nb[i] = 0;
                end else if (bnd != 0 && m_du[i] != m_tg[i]) begin
                    m_nb[i]++; ramped = 1;
                end
                m_du[i] = ramp_value(m_d0[i], m_tg[i], m_nb[i], i);
                m_at[i] = (ramped != 0 && m_du[i] == m_tg[i]) ? 1 : 0;
            end
            m_ps = bnd;
            m_phase = (m_phase + 1) % 256;
            m_cyc++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic goto(input int n);
        int g;
        g = 0;
        while (m_cyc < n && g < 100000) begin tick(); g++; end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; tv = 1'b0; td = 8'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic accept(input int d);
        tv = 1'b1; td = 8'(d);
        tick();
        tv = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (duty_o[i] !== 8'd0 || ps_o[i] !== 1'b0 || busy_o[i] !== 1'b0 || at_o[i] !== 1'b0) begin
                nbad++;
                $display("FAIL reset_outputs inst=%0d got duty=%0d ps=%b busy=%b at=%b exp 0/0/0/0",
                         i, duty_o[i], ps_o[i], busy_o[i], at_o[i]);
            end
        end
        goto(256);
        nvec++;
        if (ps_o[0] !== 1'b1) begin nbad++; $display("FAIL period_start_at_phase0 got=%b exp=1", ps_o[0]); end
        tick();
        nvec++;
        if (ps_o[0] !== 1'b0) begin nbad++; $display("FAIL period_start_width got=%b exp=0", ps_o[0]); end
    endtask

    task automatic test_soft_start();
        do_reset();
        goto(10);
        accept(100);
        goto(1023);
        nvec++;
        if (duty_o[0] !== 8'd0 || busy_o[0] !== 1'b1) begin
            nbad++; $display("FAIL soft_start_hold got duty=%0d busy=%b exp 0/1", duty_o[0], busy_o[0]);
        end
        tick();
        nvec++;
        if (duty_o[0] !== 8'd1) begin nbad++; $display("FAIL soft_start_first_step got=%0d exp=1", duty_o[0]); end
        goto(2048);
        nvec++;
        if (duty_o[0] !== 8'd2) begin nbad++; $display("FAIL soft_start_second_step got=%0d exp=2", duty_o[0]); end
        goto(3327);
        nvec++;
        if (duty_o[1] !== 8'd96 || busy_o[1] !== 1'b1) begin
            nbad++; $display("FAIL ramp_before_last got duty=%0d busy=%b exp 96/1", duty_o[1], busy_o[1]);
        end
        tick();
        nvec++;
        if (duty_o[1] !== 8'd100 || busy_o[1] !== 1'b0 || at_o[1] !== 1'b1) begin
            nbad++; $display("FAIL ramp_reach got duty=%0d busy=%b at=%b exp 100/0/1", duty_o[1], busy_o[1], at_o[1]);
        end
        tick();
        nvec++;
        if (at_o[1] !== 1'b0) begin nbad++; $display("FAIL at_target_width got=%b exp=0", at_o[1]); end
    endtask

    task automatic test_step_down();
        int seq [13] = '{92, 84, 76, 68, 60, 52, 44, 36, 28, 20, 12, 4, 3};
        goto(3400);
        accept(3);
        for (int j = 0; j < 13; j++) begin
            goto((m_cyc / 256 + 1) * 256);
            nvec++;
            if (duty_o[1] !== 8'(seq[j]) || at_o[1] !== (j == 12)) begin
                nbad++;
                $display("FAIL step_down_seq idx=%0d got duty=%0d at=%b exp %0d/%0d", j, duty_o[1], at_o[1], seq[j], j == 12);
            end
        end
        goto((m_cyc / 256 + 1) * 256);
        nvec++;
        if (duty_o[1] !== 8'd3 || busy_o[1] !== 1'b0) begin
            nbad++; $display("FAIL step_down_settle got duty=%0d busy=%b exp 3/0", duty_o[1], busy_o[1]);
        end
    endtask

    task automatic test_retarget();
        int mx;
        do_reset();
        goto(10);
        accept(200);
        goto(2048);
        nvec++;
        if (duty_o[0] !== 8'd2) begin nbad++; $display("FAIL retarget_pre got=%0d exp=2", duty_o[0]); end
        goto(2100);
        accept(1);
        mx = 0;
        while (m_cyc < 3071) begin
            tick();
            if (int'(duty_o[0]) > mx) mx = int'(duty_o[0]);
        end
        nvec++;
        if (mx != 2 || busy_o[0] !== 1'b1) begin
            nbad++; $display("FAIL retarget_no_overshoot got max=%0d busy=%b exp 2/1", mx, busy_o[0]);
        end
        tick();
        nvec++;
        if (duty_o[0] !== 8'd1 || at_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            nbad++; $display("FAIL retarget_down_step got duty=%0d at=%b busy=%b exp 1/1/0", duty_o[0], at_o[0], busy_o[0]);
        end
    endtask

    task automatic test_accept_on_boundary();
        do_reset();
        goto(10);
        accept(5);
        goto(1023);
        accept(5);
        nvec++;
        if (duty_o[0] !== 8'd0 || busy_o[0] !== 1'b1) begin
            nbad++; $display("FAIL boundary_accept_no_step got duty=%0d busy=%b exp 0/1", duty_o[0], busy_o[0]);
        end
        goto(2047);
        nvec++;
        if (duty_o[0] !== 8'd0) begin nbad++; $display("FAIL boundary_accept_div_clear got=%0d exp=0", duty_o[0]); end
        tick();
        nvec++;
        if (duty_o[0] !== 8'd1) begin nbad++; $display("FAIL boundary_accept_next_step got=%0d exp=1", duty_o[0]); end
    endtask

    task automatic test_equal_target();
        int seen;
        do_reset();
        goto(20);
        accept(0);
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            for (int i = 0; i < 2; i++) if (busy_o[i] !== 1'b0 || at_o[i] !== 1'b0) seen++;
        end
        nvec++;
        if (seen != 0) begin nbad++; $display("FAIL equal_target_idle got bad_cycles=%0d exp=0", seen); end
    endtask

    task automatic test_disable();
        do_reset();
        goto(10);
        accept(120);
        goto(3840);
        nvec++;
        if (duty_o[1] !== 8'd120) begin nbad++; $display("FAIL disable_setup got=%0d exp=120", duty_o[1]); end
        goto(3880);
        enable = 1'b0;
        #1;
        nvec++;
        if (if_a.tgt_ready !== 1'b0 || if_b.tgt_ready !== 1'b0) begin
            nbad++; $display("FAIL disable_ready got a=%b b=%b exp 0/0", if_a.tgt_ready, if_b.tgt_ready);
        end
        tv = 1'b1; td = 8'd7;
        tick();
        tv = 1'b0;
        goto(4095);
        nvec++;
        if (duty_o[1] !== 8'd120 || duty_o[0] !== 8'd3) begin
            nbad++; $display("FAIL disable_hold got b=%0d a=%0d exp 120/3", duty_o[1], duty_o[0]);
        end
        tick();
        nvec++;
        if (duty_o[1] !== 8'd0 || duty_o[0] !== 8'd0 || busy_o[0] !== 1'b0 || at_o[1] !== 1'b0) begin
            nbad++; $display("FAIL disable_zero got b=%0d a=%0d busy_a=%b at_b=%b exp 0/0/0/0",
                             duty_o[1], duty_o[0], busy_o[0], at_o[1]);
        end
        enable = 1'b1;
        accept(200);
        goto(4400);
        nvec++;
        if (duty_o[1] !== 8'd8) begin nbad++; $display("FAIL midramp_setup got=%0d exp=8", duty_o[1]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (duty_o[i] !== 8'd0 || ps_o[i] !== 1'b0 || busy_o[i] !== 1'b0 || at_o[i] !== 1'b0) begin
                nbad++; $display("FAIL midramp_reset inst=%0d got duty=%0d ps=%b busy=%b at=%b exp 0/0/0/0",
                                 i, duty_o[i], ps_o[i], busy_o[i], at_o[i]);
            end
        end
        tick();
        nvec++;
        if (duty_o[1] !== 8'd0 || busy_o[1] !== 1'b0) begin
            nbad++; $display("FAIL midramp_no_residual got duty=%0d busy=%b exp 0/0", duty_o[1], busy_o[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 20000; c++) begin
            reset = ($urandom_range(0, 4999) == 0);
            if ($urandom_range(0, 999) == 0) enable = ~enable;
            tv = ($urandom_range(0, 2999) == 0);
            td = ($urandom_range(0, 3) == 0) ? 8'(m_du[1]) : 8'($urandom_range(0, 255));
            tick();
            for (int i = 0; i < 2; i++) begin
                nvec++;
                if (duty_o[i] !== 8'(m_du[i]) || ps_o[i] !== 1'(m_ps) || at_o[i] !== 1'(m_at[i]) ||
                    busy_o[i] !== (m_du[i] != m_tg[i])) begin
                    nbad++;
                    $display("FAIL random inst=%0d cyc=%0d got duty=%0d ps=%b at=%b busy=%b exp %0d/%0d/%0d/%0d",
                             i, m_cyc, duty_o[i], ps_o[i], at_o[i], busy_o[i],
                             m_du[i], m_ps, m_at[i], m_du[i] != m_tg[i]);
                end
            end
            nvec++;
            if (if_a.tgt_ready !== enable) begin
                nbad++; $display("FAIL random_ready got=%b exp=%b", if_a.tgt_ready, enable);
            end
        end
        reset = 1'b0; enable = 1'b1; tv = 1'b0;
    endtask

    initial begin
        nvec = 0; nbad = 0;
        reset = 1'b1; enable = 1'b1; tv = 1'b0; td = 8'd0;
        test_reset();
        test_soft_start();
        test_step_down();
        test_retarget();
        test_accept_on_boundary();
        test_equal_target();
        test_disable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Soft-start / slew-limiting stage directly upstream of the 8-bit PWM generator.
- Drives the generator's `duty` input.
- Accepts a target duty over a valid/ready handshake and steps `duty_out` toward it by STEP once every PERIODS_PER_STEP PWM periods.
- Keeps an internal phase counter in lockstep with the generator's counter, so `duty_out` changes only at period boundaries and never glitches a PWM period.

Parameters:
- STEP, 1, duty increment/decrement per ramp step; legal range 1..255.
- PERIODS_PER_STEP, 4, PWM periods between ramp steps; legal range 1..65535.
- DIV_W, 16, width of the period divider counter; must satisfy 2^DIV_W >= PERIODS_PER_STEP.

Ports:
- clk  input  1  system clock, shared with the PWM generator.
- reset  input  1  synchronous, active-high reset; asserted in the same cycles as the generator's reset.
- enable  input  1  ramp enable; low forces duty to 0 at the next boundary.
- tgt_duty  input  8  requested target duty, 0..255.
- tgt_valid  input  1  target request valid.
- tgt_ready  output  1  target can be accepted this cycle.
- duty_out  output  8  registered duty; connects to the generator's `duty`.
- period_start  output  1  registered one-cycle pulse in the cycle when phase==0.
- ramp_busy  output  1  high while state==RAMP.
- at_target  output  1  one-cycle pulse in the cycle after the step that makes duty_out equal target.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: phase=0, div_cnt=0, target=0, state=IDLE, duty_out=0, period_start=0, ramp_busy=0, at_target=0.
- Reset mid-ramp aborts immediately; no residual step is applied.
- Phase counter: 8-bit, increments every cycle, wraps 255->0. After a common reset it equals the generator counter every cycle.
- Boundary: the cycle where phase==255. Any duty_out update is made only on a boundary, so the new value is in effect from the generator's counter==0.
- period_start is registered from (phase==255), so it is high exactly when phase==0.
- Handshake:
  - tgt_ready = enable.
  - Accept when tgt_valid && tgt_ready. Target register <= tgt_duty and div_cnt <= 0.
  - If tgt_duty != duty_out, state <= RAMP; otherwise state stays or returns to IDLE with no at_target pulse.
  - A new accept during RAMP retargets immediately; direction is recomputed from the current duty_out.
- Divider:
  - In RAMP, each boundary increments div_cnt.
  - On a boundary with div_cnt==PERIODS_PER_STEP-1, apply one step and set div_cnt <= 0.
  - div_cnt holds in IDLE.
- Step arithmetic (9-bit intermediates, no wrap):
  - Up: duty_out <= min(duty_out+STEP, target).
  - Down: duty_out <= (duty_out-target <= STEP) ? target : duty_out-STEP.
  - If the stepped value equals target: state <= IDLE, and at_target pulses in the next cycle.
- Simultaneous accept and step boundary: the accept wins. No step is taken that cycle and div_cnt clears.
- enable low:
  - tgt_ready=0 and incoming requests are ignored.
  - At the next boundary: duty_out <= 0, target <= 0, div_cnt <= 0, state <= IDLE, no at_target pulse.
  - Between enable falling and that boundary, duty_out holds.
- ramp_busy is registered and equals (state==RAMP).

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W=8.
  - State enum {IDLE, RAMP}.
  - PHASE_MAX=8'hFF.
  - The same DUTY_W/PHASE_MAX constants are used by the generator.
- One natural sub-module, pwm_phase_counter: 8-bit free-running counter with a boundary strobe; reusable by the generator.
- Ramp FSM, divider and step arithmetic stay in the top module.

Test Plan:
- Reset release at cycle 0, then STEP=1, P=4, accept target 100 at cycle 10:
  - duty_out stays 0 through cycle 1023 and becomes 1 at cycle 1024.
  - duty_out reaches 100 after 400 boundaries.
  - at_target pulses once; ramp_busy falls in the same cycle duty_out hits 100.
- STEP=8, from duty 100, target 3:
  - duty_out sequence is 92,84,76,68,60,52,44,36,28,20,12,4,3.
  - The last step is clamped, and duty_out never underflows.
- Retarget mid-ramp: while ramping 0->200 at duty 50, accept 20:
  - The direction flips; the first down step occurs PERIODS_PER_STEP boundaries after the accept.
  - No 51 appears.
- Accept on a boundary cycle (phase==255) with div_cnt==P-1:
  - No step is taken and div_cnt==0 next cycle.
- Accept a target equal to the current duty (e.g. 0 after reset):
  - ramp_busy stays 0 and no at_target pulse.
- Drop enable at phase 40 while duty_out=120:
  - tgt_ready=0 immediately, and a tgt_valid pulse is ignored.
  - duty_out holds at 120 until phase 255, then becomes 0.
  - Reasserting reset mid-ramp returns all outputs to their reset values on the next clk.
